// File: rtl/jzjpcc_mmio_bank.sv
// Memory-mapped bank of NUM_PORTS 32-bit output registers and synchronized
// 32-bit inputs, with sticky per-port input-change flags (write-1-to-clear).
module jzjpcc_mmio_bank #(
    parameter int unsigned NUM_PORTS   = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [29:0] BASE_WADDR  = 30'h3FFFFFF8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:2]                 address,
    input  logic                        writeEnable,
    input  logic [31:0]                 writeData,
    input  logic                        readEnable,
    output logic [31:0]                 readData,
    output logic                        readValid,
    input  logic [NUM_PORTS-1:0][31:0]  mmioInputs,
    output logic [NUM_PORTS-1:0][31:0]  mmioOutputs,
    output logic [NUM_PORTS-1:0]        changeFlags,
    output logic                        anyChange
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WADDR_W    = 30;
    localparam logic [WADDR_W-1:0] FLAG_WADDR = BASE_WADDR - 30'd1;
    localparam logic [WADDR_W-1:0] PORTS_W    = 30'(NUM_PORTS);
    localparam logic [63:0] LAST_WADDR =
        64'(BASE_WADDR) + 64'(NUM_PORTS) - 64'd1;

    // Reject illegal parameterisations at elaboration
    if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("jzjpcc_mmio_bank: NUM_PORTS must be 1..16");
    end
    if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("jzjpcc_mmio_bank: SYNC_STAGES must be 1..4");
    end
    if (BASE_WADDR == 30'd0) begin : g_bad_base_zero
        $error("jzjpcc_mmio_bank: BASE_WADDR must be nonzero");
    end
    if (LAST_WADDR > 64'h3FFFFFFF) begin : g_bad_base_wrap
        $error("jzjpcc_mmio_bank: port window exceeds address space");
    end

    logic [SYNC_STAGES-1:0][NUM_PORTS-1:0][DATA_W-1:0] sync_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]                  prev_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]                  sync;
    logic [NUM_PORTS-1:0][DATA_W-1:0]                  outputs_d;
    logic [NUM_PORTS-1:0]                              flag_set;
    logic [NUM_PORTS-1:0]                              flag_clr;
    logic [NUM_PORTS-1:0]                              flags_d;
    logic [WADDR_W-1:0]                                waddr;
    logic [WADDR_W-1:0]                                offset;
    logic                                              port_hit;
    logic                                              flag_hit;
    logic [DATA_W-1:0]                                 rd_d;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign anyChange = |changeFlags;

    // Address decode: data window above BASE_WADDR, flag register just below
    always_comb begin
        waddr    = address;
        offset   = waddr - BASE_WADDR;
        port_hit = (waddr >= BASE_WADDR) && (offset < PORTS_W);
        flag_hit = (waddr == FLAG_WADDR);
    end

    // Next-state for output registers, flags and read data
    always_comb begin
        outputs_d = mmioOutputs;
        flag_set  = '0;
        flag_clr  = '0;
        rd_d      = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            flag_set[i] = (sync[i] != prev_q[i]);
            if (writeEnable && port_hit && offset == 30'(i)) begin
                outputs_d[i] = writeData;
            end
            if (port_hit && offset == 30'(i)) begin
                rd_d = sync[i];
            end
        end
        if (writeEnable && flag_hit) begin
            flag_clr = writeData[NUM_PORTS-1:0];
        end
        // A set event in the same cycle as a clear leaves the flag set
        flags_d = (changeFlags & ~flag_clr) | flag_set;
        if (flag_hit) begin
            rd_d = 32'(changeFlags);
        end
    end

    // Synchronizer chain and previous-value tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= mmioInputs;
            for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync;
        end
    end

    // Output registers, sticky flags and registered read port
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mmioOutputs <= '0;
            changeFlags <= '0;
            readData    <= '0;
            readValid   <= 1'b0;
        end else begin
            mmioOutputs <= outputs_d;
            changeFlags <= flags_d;
            readValid   <= readEnable;
            if (readEnable) begin
                readData <= rd_d;
            end
        end
    end

endmodule

// File: tb/tb_jzjpcc_mmio_bank.sv
// Scoreboard bench: read expectations are queued at issue and popped on readValid.
module tb_jzjpcc_mmio_bank;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic [29:0]       address;
    logic              writeEnable;
    logic [31:0]       writeData;
    logic              readEnable;
    logic [31:0]       readData;
    logic              readValid;
    logic [7:0][31:0]  ins;
    logic [7:0][31:0]  outs;
    logic [7:0]        flags;
    logic              any_change;

    logic [29:0]       b_address;
    logic              b_we;
    logic [31:0]       b_wd;
    logic              b_re;
    logic [31:0]       b_rd;
    logic              b_rv;
    logic [15:0][31:0] b_ins;
    logic [15:0][31:0] b_outs;
    logic [15:0]       b_flags;
    logic              b_any;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_rd;

    localparam logic [29:0] W_FLAG = 30'h3FFFFFF7;
    localparam logic [29:0] W_OOW  = 30'h3FFFFFF6;

    jzjpcc_mmio_bank dut (
        .clock(clock), .reset(reset), .address(address),
        .writeEnable(writeEnable), .writeData(writeData),
        .readEnable(readEnable), .readData(readData), .readValid(readValid),
        .mmioInputs(ins), .mmioOutputs(outs),
        .changeFlags(flags), .anyChange(any_change)
    );

    jzjpcc_mmio_bank #(.NUM_PORTS(16), .SYNC_STAGES(4), .BASE_WADDR(30'h00000100)) dut_b (
        .clock(clock), .reset(reset), .address(b_address),
        .writeEnable(b_we), .writeData(b_wd),
        .readEnable(b_re), .readData(b_rd), .readValid(b_rv),
        .mmioInputs(b_ins), .mmioOutputs(b_outs),
        .changeFlags(b_flags), .anyChange(b_any)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        address = a; writeData = d; writeEnable = 1'b1;
        tick();
        writeEnable = 1'b0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] e);
        address = a; readEnable = 1'b1; sb.push_back(e);
        tick();
        readEnable = 1'b0;
    endtask

    // Read-port scoreboard: every readValid pulse must match a queued expectation
    always @(negedge clock) begin
        if (readValid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_spurious", 32'(readValid), 32'd0);
            end else begin
                exp_rd = sb.pop_front();
                check("rd_data", readData, exp_rd);
            end
        end
    end

    initial begin
        reset = 1'b0; address = '0; writeEnable = 1'b0; writeData = '0; readEnable = 1'b0;
        ins = '0; b_address = '0; b_we = 1'b0; b_wd = '0; b_re = 1'b0; b_ins = '0;
        tick(2);
        check("rst_valid", 32'(readValid), 32'd0);
        check("rst_data", readData, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_any", 32'(any_change), 32'd0);
        reset = 1'b1;
        tick(4);
        check("idle_flags", 32'(flags), 32'd0);

        // Single port write
        wr(30'h3FFFFFF9, 32'hDEADBEEF);
        for (int i = 0; i < 8; i++)
            check("wr_port", outs[i], (i == 1) ? 32'hDEADBEEF : 32'd0);

        // Out-of-window writes change nothing
        wr(W_OOW, 32'hCAFEF00D);
        wr(30'h00000000, 32'h12345678);
        for (int i = 0; i < 8; i++)
            check("oow_wr", outs[i], (i == 1) ? 32'hDEADBEEF : 32'd0);
        check("oow_flags", 32'(flags), 32'd0);

        // Top port boundary
        wr(30'h3FFFFFFF, 32'h00000077);
        check("top_port", outs[7], 32'h00000077);
        check("top_keep", outs[1], 32'hDEADBEEF);

        // Change detection latency on port 3
        ins[3] = 32'h5;
        tick(); check("lat_e1", 32'(flags[3]), 32'd0);
        tick(); check("lat_e2", 32'(flags[3]), 32'd0);
        tick(); check("lat_e3", 32'(flags), 32'h08);
        check("lat_any", 32'(any_change), 32'd1);
        rd(30'h3FFFFFFB, 32'h5);
        check("rd3_valid", 32'(readValid), 32'd1);

        // Flag register read and write-1-to-clear
        ins[0] = 32'h1;
        tick(3);
        check("flags_09", 32'(flags), 32'h09);
        rd(W_FLAG, 32'h9);
        wr(W_FLAG, 32'h1);
        check("w1c", 32'(flags), 32'h08);

        // Set beats clear; simultaneous read returns pre-write flags
        ins[0] = 32'h2;
        tick(2);
        address = W_FLAG; writeData = 32'h1; writeEnable = 1'b1; readEnable = 1'b1;
        sb.push_back(32'h8);
        tick();
        writeEnable = 1'b0; readEnable = 1'b0;
        check("set_wins", 32'(flags), 32'h09);
        wr(W_FLAG, 32'hFFFFFF00);
        check("clr_high_ign", 32'(flags), 32'h09);
        wr(W_FLAG, 32'h8);
        check("clr_bit3", 32'(flags), 32'h01);
        wr(W_FLAG, 32'h1);
        check("clr_all", 32'(flags), 32'd0);
        check("any_off", 32'(any_change), 32'd0);

        // Out-of-window read and back-to-back reads
        rd(W_OOW, 32'd0);
        check("oow_valid", 32'(readValid), 32'd1);
        readEnable = 1'b1;
        address = 30'h3FFFFFF9; sb.push_back(32'd0); tick();
        check("b2b_v1", 32'(readValid), 32'd1);
        address = 30'h3FFFFFFF; sb.push_back(32'd0); tick();
        check("b2b_v2", 32'(readValid), 32'd1);
        address = 30'h3FFFFFFB; sb.push_back(32'h5); tick();
        check("b2b_v3", 32'(readValid), 32'd1);
        readEnable = 1'b0;
        tick();
        check("hold_valid", 32'(readValid), 32'd0);
        check("hold_data", readData, 32'h5);

        // Async reset between edges, with a read pending
        ins[5] = 32'h1;
        tick(3);
        check("pre_rst_flags", 32'(flags), 32'h20);
        readEnable = 1'b1; address = 30'h3FFFFFFB;
        #2 reset = 1'b0;
        #1;
        check("arst_out1", outs[1], 32'd0);
        check("arst_out7", outs[7], 32'd0);
        check("arst_flags", 32'(flags), 32'd0);
        check("arst_any", 32'(any_change), 32'd0);
        check("arst_rdata", readData, 32'd0);
        check("arst_valid", 32'(readValid), 32'd0);
        readEnable = 1'b0;
        ins = '0;
        tick();
        check("arst_nopulse", 32'(readValid), 32'd0);
        reset = 1'b1;
        tick(5);
        check("rel_zero_flags", 32'(flags), 32'd0);

        // Nonzero input across reset release flags once
        reset = 1'b0;
        ins[2] = 32'h7;
        tick(2);
        reset = 1'b1;
        tick(2);
        check("rel_e2", 32'(flags), 32'd0);
        tick();
        check("rel_e3", 32'(flags), 32'h04);
        wr(W_FLAG, 32'h4);
        tick(4);
        check("rel_once", 32'(flags), 32'd0);

        // Second configuration: 16 ports, 4 sync stages, base 0x100
        b_ins[15] = 32'h1;
        tick(4);
        check("b_lat4", 32'(b_flags[15]), 32'd0);
        tick();
        check("b_lat5", 32'(b_flags), 32'h8000);
        check("b_any", 32'(b_any), 32'd1);
        b_address = 30'h10F; b_wd = 32'h12345678; b_we = 1'b1;
        tick();
        b_we = 1'b0;
        check("b_out15", b_outs[15], 32'h12345678);
        check("b_out14", b_outs[14], 32'd0);
        b_address = 30'h0FF; b_wd = 32'h8000; b_we = 1'b1;
        tick();
        b_we = 1'b0;
        check("b_clr15", 32'(b_flags), 32'd0);
        check("b_novalid", 32'(b_rv), 32'd0);

        tick(2);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jzjpcc_mmio_bank.md
JZJPCC_MMIO_BANK -- requirements
Module: jzjpcc_mmio_bank

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 8, giving the number of 32-bit input/output port pairs, legal range 1..16.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth, legal range 1..4.
REQ-003 The block SHALL have parameter BASE_WADDR [31:2], default 30'h3FFFFFF8, giving the word address of data port 0 (byte FFFFFFE0).
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 address  input  [31:2]  word address of the current access.
REQ-007 writeEnable  input  1  write strobe for the current cycle.
REQ-008 writeData  input  32  write data.
REQ-009 readEnable  input  1  read request for the current cycle.
REQ-010 readData  output  32  registered read result.
REQ-011 readValid  output  1  one-cycle pulse qualifying readData.
REQ-012 mmioInputs  input  32 x NUM_PORTS  external inputs, asynchronous to clock.
REQ-013 mmioOutputs  output  32 x NUM_PORTS  output registers.
REQ-014 changeFlags  output  NUM_PORTS  sticky per-port input-change flags.
REQ-015 anyChange  output  1  OR of changeFlags, combinational.

Function
REQ-016 Address map SHALL be: data port i at BASE_WADDR+i; flag register at BASE_WADDR-1; all other addresses are outside the window.
REQ-017 Elaboration SHALL fail if NUM_PORTS or SYNC_STAGES is out of range, BASE_WADDR is 0, or BASE_WADDR+NUM_PORTS-1 exceeds 30'h3FFFFFFF.
REQ-018 Each mmioInputs[i] SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized value sync_i.
REQ-019 A prev_i register SHALL load sync_i every cycle; when sync_i != prev_i in any bit, changeFlags[i] SHALL set on the next edge.
REQ-020 Latency from a stable change on mmioInputs[i] (meeting setup) to changeFlags[i]=1 SHALL be SYNC_STAGES+1 rising edges.
REQ-021 A write to data port i SHALL load mmioOutputs[i] with writeData on that edge; other ports are unchanged.
REQ-022 A write to the flag register SHALL clear changeFlags[i] for each i where writeData[i]=1 (write-1-to-clear); writeData bits at NUM_PORTS and above are ignored.
REQ-023 If a set event and a clear for the same flag occur in the same cycle, the set SHALL win and the flag stays 1.
REQ-024 A readEnable cycle SHALL produce readValid=1 and readData on the following cycle; otherwise readValid=0 and readData holds its last value.
REQ-025 Read of data port i SHALL return sync_i (never mmioOutputs[i]); read of the flag register SHALL return changeFlags zero-extended to 32 bits; out-of-window read SHALL return 0 with readValid=1.
REQ-026 A simultaneous read and write of the flag register SHALL return the pre-write flag value.
REQ-027 Out-of-window writes SHALL change no state.
REQ-028 readEnable and writeEnable SHALL be honoured independently in the same cycle with no stall or back-pressure.

Reset
REQ-029 While reset=0, the block SHALL immediately clear mmioOutputs, changeFlags, readData, readValid, all synchronizer stages and all prev registers to 0.
REQ-030 After reset release, any input whose synchronized value is nonzero SHALL set its flag once, as a change from 0.
REQ-031 Reset asserted mid-read SHALL suppress the pending readValid pulse.

Verification
REQ-032 Scenario: default params; write 32'hDEADBEEF to byte FFFFFFE4 -> mmioOutputs[1]=32'hDEADBEEF after that edge, all other outputs 0.
REQ-033 Scenario: mmioInputs[3] goes 0 -> 32'h5 -> changeFlags[3]=1 and anyChange=1 exactly 3 edges later; a read of byte FFFFFFEC one cycle after that returns 32'h5 with readValid=1.
REQ-034 Scenario: flags=8'b0000_1001; write 32'h1 to byte FFFFFFDC -> flags=8'b0000_1000. Repeat the write in the same cycle a new change on port 0 is detected -> flag 0 stays 1.
REQ-035 Scenario: read byte FFFFFFD8 (out of window) -> readData=0, readValid=1 next cycle; back-to-back reads on 3 consecutive cycles -> 3 consecutive readValid pulses.
REQ-036 Scenario: NUM_PORTS=16, SYNC_STAGES=4, BASE_WADDR=30'h00000100; toggle input 15 -> flag 15 set after 5 edges; write to word 30'h10F -> mmioOutputs[15] updated.
REQ-037 Scenario: drive reset=0 asynchronously between edges with outputs and flags nonzero -> all outputs 0 before the next edge; release reset with inputs held at 0 -> no flags set.
